method_stream_adapter: RTL and testbench

- Converts a BSV ActionValue method port group (RDY_/EN_/result) into a valid/ready stream whose payload is split into equal-width fields.
- Buffers results in a DEPTH-entry FIFO.
- Parametrised successor to the fixed per-method port expansion wrapper: generalises field width, field count and buffering, and adds sequential flow control.
- Sits between a generated BSV module and hand-written RTL consumers.

---
 rtl/method_stream_adapter.sv | 97 +++++++++
 tb/tb_method_stream_adapter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/method_stream_adapter.sv
// method_stream_adapter: turns a BSV ActionValue method (RDY_/EN_/result)
// into a valid/ready stream backed by a DEPTH-entry FIFO. The payload is
// NUM_FIELDS fields of FIELD_W bits, and field 0 sits in the MSBs.
// Optional statistics counters: define METHOD_STREAM_ADAPTER_STATS_EN.
//
// Handshake: the BSV side fires (EN_m=1) only when RDY_m=1 and the FIFO can
// take an entry this cycle. The stream side transfers on any edge where
// out_valid & out_ready are both 1. out_valid does not depend on out_ready.
// EN_m may depend on out_ready, because a full FIFO that pops in the same
// cycle can also accept a push.
module method_stream_adapter #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 3,
  parameter int DEPTH      = 4,
  localparam int RES_W     = FIELD_W * NUM_FIELDS,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RDY_m,
  output logic             EN_m,
  input  logic [RES_W-1:0] m_result,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
`ifdef METHOD_STREAM_ADAPTER_STATS_EN
  output logic [31:0]      stat_pushes,
  output logic [31:0]      stat_pops,
  output logic [31:0]      stat_full_stalls,
`endif
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [RES_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             space;
  logic             push;
  logic             pop;

  // A slot is free when not full, or when the head leaves in this same cycle.
  assign space     = (count < CNT_W'(DEPTH)) | (out_valid & out_ready);
  assign EN_m      = RDY_m & ~RST & ~flush & space;
  assign push      = EN_m;
  // A flush discards any pop presented in the same cycle.
  assign pop       = out_valid & out_ready & ~flush & ~RST;
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];

  // Storage, pointers and occupancy. RST beats flush, and flush beats push/pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= m_result;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef METHOD_STREAM_ADAPTER_STATS_EN
  logic full_stall;
  assign full_stall = RDY_m & ~RST & ~flush & ~space;

  // Saturating event counters. They clear only on RST and ignore flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_pushes      <= '0;
      stat_pops        <= '0;
      stat_full_stalls <= '0;
    end else begin
      if (push && stat_pushes != 32'hFFFF_FFFF) stat_pushes <= stat_pushes + 32'd1;
      if (pop && stat_pops != 32'hFFFF_FFFF) stat_pops <= stat_pops + 32'd1;
      if (full_stall && stat_full_stalls != 32'hFFFF_FFFF)
        stat_full_stalls <= stat_full_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_method_stream_adapter.sv
// Table-driven bench for method_stream_adapter (FIELD_W=4, NUM_FIELDS=3, DEPTH=4).
module tb_method_stream_adapter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RDY_m;
  logic        EN_m;
  logic [11:0] m_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [2:0]  count;
`ifdef METHOD_STREAM_ADAPTER_STATS_EN
  logic [31:0] stat_pushes, stat_pops, stat_full_stalls;
`endif

  method_stream_adapter #(.FIELD_W(4), .NUM_FIELDS(3), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .RDY_m(RDY_m), .EN_m(EN_m), .m_result(m_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef METHOD_STREAM_ADAPTER_STATS_EN
    .stat_pushes(stat_pushes), .stat_pops(stat_pops),
    .stat_full_stalls(stat_full_stalls),
`endif
    .count(count)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst, rdy;
    logic [11:0] res;
    logic        fl, ordy;
    logic        en, ov;
    logic [11:0] od;
    logic [2:0]  cnt;
  } vec_t;

  vec_t        vq[$];
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic [11:0] res,
                     input logic fl, input logic ordy, input logic en,
                     input logic ov, input logic [11:0] od, input logic [2:0] cnt);
    vec_t v;
    v = '{rst: rst, rdy: rdy, res: res, fl: fl, ordy: ordy,
          en: en, ov: ov, od: od, cnt: cnt};
    vq.push_back(v);
  endtask

  // Drive the inputs on the falling edge, then sample 1 ns later, well before the next rising edge.
  task automatic drive(input logic rst, input logic rdy, input logic [11:0] res,
                       input logic fl, input logic ordy);
    @(negedge CLK);
    RST = rst; RDY_m = rdy; m_result = res; flush = fl; out_ready = ordy;
    #1;
  endtask

  logic [3:0] exp_f [3];
  int   pushed, popped, cyc;
  logic exp_en, do_pop;

  initial begin
    RST = 1'b1; RDY_m = 1'b0; m_result = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge CLK);

    //   rst rdy res     fl ordy | en ov od      cnt
    add(1, 1, 12'h000, 0, 0,   0, 0, 12'h000, 0);  // reset held, RDY_m high
    add(1, 1, 12'h000, 0, 0,   0, 0, 12'h000, 0);
    add(0, 1, 12'hABC, 0, 0,   1, 0, 12'h000, 0);  // first push, no bypass
    add(0, 0, 12'h000, 0, 0,   0, 1, 12'hABC, 1);  // visible next cycle
    add(0, 0, 12'h000, 0, 1,   0, 1, 12'hABC, 1);  // pop it
    add(0, 1, 12'h001, 0, 0,   1, 0, 12'h000, 0);  // fill 1..4
    add(0, 1, 12'h002, 0, 0,   1, 1, 12'h001, 1);
    add(0, 1, 12'h003, 0, 0,   1, 1, 12'h001, 2);
    add(0, 1, 12'h004, 0, 0,   1, 1, 12'h001, 3);
    add(0, 1, 12'h005, 0, 0,   0, 1, 12'h001, 4);  // full: stall
    add(0, 1, 12'h005, 0, 0,   0, 1, 12'h001, 4);
    add(0, 1, 12'h005, 0, 1,   1, 1, 12'h001, 4);  // full pass-through
    add(0, 1, 12'h006, 0, 1,   1, 1, 12'h002, 4);
    add(0, 1, 12'h007, 0, 1,   1, 1, 12'h003, 4);
    add(0, 1, 12'h008, 0, 1,   1, 1, 12'h004, 4);
    add(0, 1, 12'h009, 0, 1,   1, 1, 12'h005, 4);
    add(0, 1, 12'h00A, 0, 1,   1, 1, 12'h006, 4);
    add(0, 1, 12'h00B, 0, 1,   1, 1, 12'h007, 4);
    add(0, 1, 12'h00C, 0, 1,   1, 1, 12'h008, 4);
    add(0, 0, 12'h000, 0, 1,   0, 1, 12'h009, 4);  // drain to 3
    add(0, 1, 12'hFFF, 1, 1,   0, 1, 12'h00A, 3);  // flush blocks push and pop
    add(0, 1, 12'h123, 0, 0,   1, 0, 12'h00C, 0);  // pointers back at 0 (stale mem[0])
    add(0, 0, 12'h000, 0, 0,   0, 1, 12'h123, 1);  // post-flush push read first

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].rdy, vq[i].res, vq[i].fl, vq[i].ordy);
      chk($sformatf("v%0d_en", i),    32'(EN_m),      32'(vq[i].en));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vq[i].ov));
      chk($sformatf("v%0d_data", i),  32'(out_data),  32'(vq[i].od));
      chk($sformatf("v%0d_count", i), 32'(count),     32'(vq[i].cnt));
    end

    // Reset in the middle of operation, with one entry stored
    drive(1, 1, 12'h000, 0, 0);
    chk("midrst_en0", 32'(EN_m), 32'd0);
    drive(1, 1, 12'h000, 0, 0);
    chk("midrst_en1", 32'(EN_m), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    drive(0, 1, 12'h5E7, 0, 0);
    chk("postrst_en", 32'(EN_m), 32'd1);

    // Check the field split. Field 0 sits in the MSBs. Pop the entry in the same cycle.
    exp_f[0] = 4'h5; exp_f[1] = 4'hE; exp_f[2] = 4'h7;
    drive(0, 0, 12'h000, 0, 1);
    chk("field_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++)
      chk($sformatf("field%0d", k), 32'(out_data[(3-k)*4-1 -: 4]), 32'(exp_f[k]));

    // Wrap and order: push payloads 0..9 while out_ready is random, checked against a queue model
    pushed = 0; popped = 0; cyc = 0;
    exp_q.delete();
    while (popped < 10 && cyc < 200) begin
      drive(0, (pushed < 10), 12'(pushed), 0, 1'($urandom_range(0, 1)));
      do_pop = (exp_q.size() != 0) && out_ready;
      exp_en = RDY_m && (exp_q.size() < 4 || do_pop);
      chk("wrap_count", 32'(count), 32'(exp_q.size()));
      chk("wrap_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("wrap_en", 32'(EN_m), 32'(exp_en));
      if (do_pop) begin
        chk("wrap_data", 32'(out_data), 32'(exp_q.pop_front()));
        popped++;
      end
      if (exp_en) begin
        exp_q.push_back(12'(pushed));
        pushed++;
      end
      cyc++;
    end
    chk("wrap_done", 32'(popped), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
